sw_egress_sched: RTL and testbench

SW_EGRESS_SCHED -- requirements
Module: sw_egress_sched

---
 rtl/sw_egress_sched.sv | 141 ++++++++++++++
 tb/tb_sw_egress_sched.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/sw_egress_sched.sv
// Egress-port scheduler: round-robin arbitration of 4 ingress heads into a registered output stage.
// Optional starvation promotion is enabled by defining SW_SCHED_STARVE_EN.
module sw_egress_sched #(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req_valid,
  input  logic [15:0] req_src,
  input  logic [15:0] req_tgt,
  input  logic [31:0] req_data,
  output logic [3:0]  req_ready,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [3:0]  out_src,
  output logic [3:0]  out_tgt,
  output logic [7:0]  out_data,
  output logic [1:0]  rr_ptr
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t     state_r, state_nxt_s;
  logic       decide_s;
  logic [1:0] win_s;
  logic [3:0] grant_s;
  logic [3:0] out_src_r, out_tgt_r;
  logic [7:0] out_data_r;
  logic [1:0] rr_ptr_r;

  if (STARVE_LIMIT == 0 || STARVE_LIMIT > 15) begin : g_starve_limit_range
    $error("STARVE_LIMIT must be within 1..15");
  end

  // Scan downwards so the last hit kept is the first valid index from p upwards.
  function automatic logic [1:0] rr_pick(input logic [3:0] v, input logic [1:0] p);
    logic [1:0] idx;
    rr_pick = p;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (v[idx]) rr_pick = idx;
      else        rr_pick = rr_pick;
    end
  endfunction

`ifdef SW_SCHED_STARVE_EN
  localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT);

  logic [3:0] cnt_r [4];
  logic [3:0] starving_s;

  function automatic logic [1:0] low_pick(input logic [3:0] v);
    low_pick = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (v[k]) low_pick = 2'(k);
      else      low_pick = low_pick;
    end
  endfunction

  // Starving requesters override round-robin, lowest index first.
  always_comb begin
    for (int i = 0; i < 4; i++) starving_s[i] = req_valid[i] && (cnt_r[i] >= LIMIT_C);
    if (|starving_s) win_s = low_pick(starving_s);
    else             win_s = rr_pick(req_valid, rr_ptr_r);
  end

  // Wait counters: count lost decisions while valid, saturate at 15.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) cnt_r[i] <= 4'd0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!req_valid[i])                               cnt_r[i] <= 4'd0;
        else if (decide_s && (win_s == 2'(i)))           cnt_r[i] <= 4'd0;
        else if (decide_s && (cnt_r[i] != 4'd15))        cnt_r[i] <= cnt_r[i] + 4'd1;
        else                                             cnt_r[i] <= cnt_r[i];
      end
    end
  end
`else
  // Pure round-robin winner selection.
  always_comb begin
    win_s = rr_pick(req_valid, rr_ptr_r);
  end
`endif

  // Decision qualification, pop pulse and next state.
  always_comb begin
    decide_s    = 1'b0;
    grant_s     = 4'b0000;
    state_nxt_s = state_r;
    if ((state_r == IDLE || out_ready) && (req_valid != 4'b0000)) decide_s = 1'b1;
    else                                                          decide_s = 1'b0;
    if (decide_s && rst_n) grant_s = 4'b0001 << win_s;
    else                   grant_s = 4'b0000;
    case (state_r)
      IDLE: begin
        if (decide_s) state_nxt_s = SEND;
        else          state_nxt_s = IDLE;
      end
      SEND: begin
        if (decide_s)       state_nxt_s = SEND;
        else if (out_ready) state_nxt_s = IDLE;
        else                state_nxt_s = SEND;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register and output stage; fields load only on a decision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      out_src_r  <= 4'd0;
      out_tgt_r  <= 4'd0;
      out_data_r <= 8'd0;
      rr_ptr_r   <= 2'd0;
    end else begin
      state_r <= state_nxt_s;
      if (decide_s) begin
        out_src_r  <= req_src[{win_s, 2'b00} +: 4];
        out_tgt_r  <= req_tgt[{win_s, 2'b00} +: 4];
        out_data_r <= req_data[{win_s, 3'b000} +: 8];
        rr_ptr_r   <= win_s + 2'd1;
      end else begin
        out_src_r  <= out_src_r;
        out_tgt_r  <= out_tgt_r;
        out_data_r <= out_data_r;
        rr_ptr_r   <= rr_ptr_r;
      end
    end
  end

  assign req_ready = grant_s;
  assign out_valid = (state_r == SEND);
  assign out_src   = out_src_r;
  assign out_tgt   = out_tgt_r;
  assign out_data  = out_data_r;
  assign rr_ptr    = rr_ptr_r;

endmodule

// File: tb/tb_sw_egress_sched.sv
// Self-checking bench for sw_egress_sched: directed scenarios followed by random traffic
// compared against a transaction-level reference model.
module tb_sw_egress_sched;
`ifdef SW_SCHED_STARVE_EN
  localparam int SL = 2;
`else
  localparam int SL = 8;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [15:0] req_src;
  logic [15:0] req_tgt;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        out_ready;
  logic        out_valid;
  logic [3:0]  out_src;
  logic [3:0]  out_tgt;
  logic [7:0]  out_data;
  logic [1:0]  rr_ptr;

  int checks = 0;
  int errors = 0;

  bit         m_busy;
  int         m_ptr;
  logic [3:0] m_src, m_tgt;
  logic [7:0] m_data;
  int         m_cnt [4];

  sw_egress_sched #(.STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_src(req_src),
    .req_tgt(req_tgt), .req_data(req_data), .req_ready(req_ready),
    .out_ready(out_ready), .out_valid(out_valid), .out_src(out_src),
    .out_tgt(out_tgt), .out_data(out_data), .rr_ptr(rr_ptr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_winner(input logic [3:0] v);
`ifdef SW_SCHED_STARVE_EN
    for (int i = 0; i < 4; i++) if (v[i] && m_cnt[i] >= SL) return i;
`endif
    for (int k = 0; k < 4; k++) if (v[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    return 0;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_ptr = 0; m_src = 4'd0; m_tgt = 4'd0; m_data = 8'd0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
  endtask

  task automatic rnd_fields();
    req_src  = 16'($urandom);
    req_tgt  = 16'($urandom);
    req_data = $urandom;
  endtask

  // Called at posedge+1; returns at the next posedge+1 with the model advanced.
  task automatic step(input logic [3:0] v, input logic o);
    bit dec;
    int w;
    logic [3:0] exp_rdy;
    req_valid = v;
    out_ready = o;
    #1;
    dec = (!m_busy || o) && (v != 4'd0);
    w = dec ? model_winner(v) : 0;
    exp_rdy = dec ? 4'(1 << w) : 4'd0;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("out_valid", 32'(out_valid), 32'(m_busy));
    chk("out_src",   32'(out_src),   32'(m_src));
    chk("out_tgt",   32'(out_tgt),   32'(m_tgt));
    chk("out_data",  32'(out_data),  32'(m_data));
    chk("rr_ptr",    32'(rr_ptr),    32'(m_ptr));
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (!v[i]) m_cnt[i] = 0;
      else if (dec && i == w) m_cnt[i] = 0;
      else if (dec && m_cnt[i] < 15) m_cnt[i]++;
    end
    if (dec) begin
      m_src  = req_src[4*w +: 4];
      m_tgt  = req_tgt[4*w +: 4];
      m_data = req_data[8*w +: 8];
      m_busy = 1;
      m_ptr  = (w + 1) % 4;
    end else if (m_busy && o) begin
      m_busy = 0;
    end
  endtask

  // Assert reset mid-cycle (asynchronous effect), hold over one edge, release at posedge+1.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_rr_ptr",    32'(rr_ptr),    32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_out_src",   32'(out_src),   32'd0);
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_hold_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    int exp31 [5];
    exp31 = '{1, 2, 3, 0, 1};
    rst_n = 1'b0; req_valid = 4'd0; out_ready = 1'b0;
    req_src = 16'd0; req_tgt = 16'd0; req_data = 32'd0;
    model_reset();
    @(posedge clk);
    #1;
    req_valid = 4'b1111;
    do_reset();

    // Two alternating requesters, continuous acceptance.
    for (int k = 0; k < 4; k++) begin
      rnd_fields();
      step(4'b0101, 1'b1);
    end
    chk("r030_ptr", 32'(rr_ptr), 32'd3);

    // Backpressure: held packet of requester 2 stays stable.
    rnd_fields();
    req_src[11:8] = 4'b0100; req_tgt[11:8] = 4'b0001; req_data[23:16] = 8'hA5;
    step(4'b0100, 1'b1);
    for (int k = 0; k < 5; k++) begin
      step(4'b0100, 1'b0);
      chk("r032_data", 32'(out_data), 32'hA5);
      chk("r032_src",  32'(out_src),  32'h4);
    end
    step(4'b0000, 1'b1);
    chk("r032_drain", 32'(out_valid), 32'd0);

    // Single request then idle.
    rnd_fields();
    step(4'b1000, 1'b1);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
    chk("r033_idle", 32'(out_valid), 32'd0);
    chk("r033_ptr",  32'(rr_ptr),    32'd0);

    // Reset while sending.
    rnd_fields();
    step(4'b0011, 1'b0);
    step(4'b0011, 1'b0);
    req_valid = 4'b1111; out_ready = 1'b1;
    do_reset();

`ifndef SW_SCHED_STARVE_EN
    // All requesters valid: pointer walks 1,2,3,0,1.
    for (int k = 0; k < 5; k++) begin
      rnd_fields();
      step(4'b1111, 1'b1);
      chk("r031_ptr", 32'(rr_ptr), 32'(exp31[k]));
    end
`else
    // Requester 3 promoted after losing two decisions.
    rnd_fields();
    step(4'b1001, 1'b1);
    step(4'b1010, 1'b1);
    step(4'b1100, 1'b1);
    chk("r035_ptr",  32'(rr_ptr),   32'd0);
    chk("r035_data", 32'(out_data), 32'(req_data[31:24]));
`endif

    // Random traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      rnd_fields();
      if ($urandom_range(0, 49) == 0) begin
        req_valid = 4'($urandom_range(0, 15));
        do_reset();
      end else begin
        step(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
